// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: hall-to-sector map, sector stepping helpers, meter states
// and the default tick prescale also used by the PWM clock divider.
package bldc_pkg;

    localparam int         PWM_PRESCALE = 42;
    localparam logic [2:0] SEC_INVALID  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STALL
    } meter_state_e;

    // Gray-style hall sequence; 000 and 111 can never occur on a healthy motor.
    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd0;
            3'b011:  return 3'd1;
            3'b010:  return 3'd2;
            3'b110:  return 3'd3;
            3'b100:  return 3'd4;
            3'b101:  return 3'd5;
            default: return SEC_INVALID;
        endcase
    endfunction

    function automatic logic [2:0] sector_fwd(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] sector_rev(input logic [2:0] s);
        return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/hall_sync_filter.sv
// Two-flop synchroniser for the raw hall pins plus an optional stability filter
// (enabled with HALL_FILTER_EN) that accepts a code only after FILT_LEN equal samples.
module hall_sync_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    output logic [2:0] code
);

    logic [2:0] meta;
    logic [2:0] hs;

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            hs   <= '0;
        end else begin
            meta <= hall;
            hs   <= meta;
        end
    end

`ifdef HALL_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [2:0]    cand;
    logic [2:0]    clean;
    logic [FW-1:0] run_len;

    // run_len counts consecutive samples of cand that differ from the accepted code
    always_ff @(posedge clk) begin
        if (rst) begin
            cand    <= '0;
            clean   <= '0;
            run_len <= '0;
        end else if (hs == clean) begin
            cand    <= hs;
            run_len <= '0;
        end else if (hs != cand) begin
            cand    <= hs;
            run_len <= FW'(1);
            if (FILT_LEN == 1) begin
                clean   <= hs;
                run_len <= '0;
            end
        end else if (int'(run_len) + 1 >= FILT_LEN) begin
            clean   <= hs;
            run_len <= '0;
        end else begin
            run_len <= run_len + FW'(1);
        end
    end

    assign code = clean;
`else
    assign code = hs;
`endif

endmodule

// File: rtl/hall_period_meter.sv
// BLDC hall period meter: tick-counts the interval between commutation edges and reports
// period, sector, direction, stall and invalid-code pulses. Optional filter: HALL_FILTER_EN.
module hall_period_meter
    import bldc_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 60000,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       hall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [2:0]       sector,
    output logic             dir,
    output logic             stall,
    output logic             hall_err
);

    localparam int PW = $clog2(PRESCALE);

    if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
        $error("PRESCALE must be within 2..255");
    end
    if (TIMEOUT >= (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**CNT_W - 1");
    end

    logic [2:0]       code;
    logic [2:0]       code_q;
    logic [2:0]       sec_now;
    logic [2:0]       last_sec;
    logic [PW-1:0]    pcnt;
    logic [CNT_W-1:0] cnt;
    meter_state_e     state;

    logic tick;
    logic code_chg;
    logic valid_now;
    logic edge_det;
    logic fwd_step;
    logic rev_step;
    logic timed_out;

    hall_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .hall (hall),
        .code (code)
    );

    assign sec_now   = hall_to_sector(code);
    assign valid_now = (sec_now != SEC_INVALID);
    assign code_chg  = (code != code_q);
    // Invalid codes are transparent: edges compare against the last valid sector.
    assign edge_det  = valid_now && (sec_now != last_sec) && (state != IDLE);
    assign fwd_step  = (sec_now == sector_fwd(last_sec));
    assign rev_step  = (sec_now == sector_rev(last_sec));
    assign tick      = en && (pcnt == PW'(PRESCALE - 1));
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pcnt         <= '0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            sector       <= SEC_INVALID;
            last_sec     <= SEC_INVALID;
            dir          <= 1'b1;
            stall        <= 1'b0;
            hall_err     <= 1'b0;
            code_q       <= '0;
        end else begin
            code_q       <= code;
            hall_err     <= code_chg && !valid_now;
            period_valid <= 1'b0;

            if (!en) begin
                // Interval in flight is dropped; period, dir and sector keep their values.
                state <= IDLE;
                pcnt  <= '0;
                cnt   <= '0;
                stall <= 1'b0;
            end else begin
                sector <= sec_now;
                pcnt   <= tick ? '0 : pcnt + PW'(1);
                if (tick && !timed_out)
                    cnt <= cnt + CNT_W'(1);

                case (state)
                    IDLE: begin
                        pcnt <= '0;
                        cnt  <= '0;
                        if (valid_now) begin
                            last_sec <= sec_now;
                            state    <= ARM;
                        end
                    end
                    ARM, RUN, STALL: begin
                        if (edge_det) begin
                            // Every accepted edge re-phases the prescaler.
                            last_sec <= sec_now;
                            pcnt     <= '0;
                            cnt      <= '0;
                            stall    <= 1'b0;
                            state    <= RUN;
                            if (fwd_step)
                                dir <= 1'b1;
                            else if (rev_step)
                                dir <= 1'b0;
                            if (state == RUN && (fwd_step || rev_step)) begin
                                period       <= cnt + CNT_W'(tick);
                                period_valid <= 1'b1;
                            end
                        end else if (state == RUN && timed_out) begin
                            state <= STALL;
                            stall <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hall_period_meter.sv
// Self-checking bench for hall_period_meter: scoreboard of expected period reports plus
// per-scenario checks of sector, dir, stall and hall_err. Honours HALL_FILTER_EN.
module tb_hall_period_meter;

    localparam int PRESCALE = 42;
    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 250;
    localparam int FILT_LEN = 4;
`ifdef HALL_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic             dir;
        logic [2:0]       sector;
    } exp_t;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             en   = 1'b0;
    logic [2:0]       hall = 3'b001;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [2:0]       sector;
    logic             dir;
    logic             stall;
    logic             hall_err;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;

    hall_period_meter #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hall         (hall),
        .period       (period),
        .period_valid (period_valid),
        .sector       (sector),
        .dir          (dir),
        .stall        (stall),
        .hall_err     (hall_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] code, input bit has_exp,
                         input int p, input logic d, input logic [2:0] s);
        exp_t e;
        hall = code;
        if (has_exp) begin
            e.period = CNT_W'(p);
            e.dir    = d;
            e.sector = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic sb_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (hall_err) err_pulses++;
            if (period_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_valid period=%0d sector=%0d dir=%0d", period, sector, dir);
                end else begin
                    e = exp_q.pop_front();
                    if (period !== e.period || dir !== e.dir || sector !== e.sector) begin
                        errors++;
                        $display("FAIL sb_report got p=%0d d=%0d s=%0d exp p=%0d d=%0d s=%0d",
                                 period, dir, sector, e.period, e.dir, e.sector);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        cyc(3);
        checks++;
        if (period !== '0 || period_valid !== 1'b0) begin
            errors++; $display("FAIL reset_period got p=%0d v=%0d exp p=0 v=0", period, period_valid);
        end
        checks++;
        if (sector !== 3'd7 || dir !== 1'b1) begin
            errors++; $display("FAIL reset_sector_dir got s=%0d d=%0d exp s=7 d=1", sector, dir);
        end
        checks++;
        if (stall !== 1'b0 || hall_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got stall=%0d err=%0d exp 0 0", stall, hall_err);
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_forward();
        en = 1'b1;
        cyc(LAT + 102);
        checks++;
        if (sector !== 3'd0) begin errors++; $display("FAIL fwd_arm_sector got=%0d exp=0", sector); end
        drive(3'b011, 0, 0, 0, 0);
        cyc(LAT - 1);
        checks++;
        if (sector !== 3'd0) begin errors++; $display("FAIL fwd_latency_early got=%0d exp=0", sector); end
        cyc(1);
        checks++;
        if (sector !== 3'd1 || period !== '0) begin
            errors++; $display("FAIL fwd_first_edge got s=%0d p=%0d exp s=1 p=0", sector, period);
        end
        cyc(4200 - LAT);
        drive(3'b010, 1, 100, 1'b1, 3'd2);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fwd_edge2_missing pending=%0d exp=0", exp_q.size()); end
        cyc(4200 - LAT - 1);
        drive(3'b110, 1, 100, 1'b1, 3'd3);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fwd_edge3_missing pending=%0d exp=0", exp_q.size()); end
        cyc(4200 - LAT - 1);
    endtask

    task automatic test_skip_reverse();
        drive(3'b101, 0, 0, 0, 0);
        cyc(LAT + 1);
        checks++;
        if (sector !== 3'd5 || dir !== 1'b1 || period !== CNT_W'(100)) begin
            errors++; $display("FAIL skip_edge got s=%0d d=%0d p=%0d exp s=5 d=1 p=100", sector, dir, period);
        end
        cyc(8400 - LAT - 1);
        drive(3'b100, 1, 200, 1'b0, 3'd4);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rev_edge1_missing pending=%0d exp=0", exp_q.size()); end
        cyc(8400 - LAT - 1);
        drive(3'b110, 1, 200, 1'b0, 3'd3);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rev_edge2_missing pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        cyc(10400 - LAT - 1);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL stall_early got=%0d exp=0", stall); end
        cyc(600);
        checks++;
        if (stall !== 1'b1 || period !== CNT_W'(200)) begin
            errors++; $display("FAIL stall_set got stall=%0d p=%0d exp stall=1 p=200", stall, period);
        end
        drive(3'b010, 0, 0, 0, 0);
        cyc(LAT + 1);
        checks++;
        if (stall !== 1'b0 || sector !== 3'd2 || period !== CNT_W'(200)) begin
            errors++; $display("FAIL stall_exit got stall=%0d s=%0d p=%0d exp 0 2 200", stall, sector, period);
        end
        cyc(4200 - LAT - 1);
        drive(3'b011, 1, 100, 1'b0, 3'd1);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_resume_missing pending=%0d exp=0", exp_q.size()); end
        cyc(2000 - LAT - 1);
    endtask

    task automatic test_invalid();
        int e0;
        e0 = err_pulses;
        drive(3'b111, 0, 0, 0, 0);
        cyc(LAT);
        checks++;
        if (sector !== 3'd7) begin errors++; $display("FAIL invalid_sector got=%0d exp=7", sector); end
        cyc(10 - LAT);
        drive(3'b011, 0, 0, 0, 0);
        cyc(LAT + 1);
        checks++;
        if (err_pulses != e0 + 1) begin
            errors++; $display("FAIL invalid_err_pulse got=%0d exp=%0d", err_pulses - e0, 1);
        end
        checks++;
        if (sector !== 3'd1) begin errors++; $display("FAIL invalid_recover got=%0d exp=1", sector); end
        cyc(2190 - LAT - 1);
        drive(3'b001, 1, 100, 1'b0, 3'd0);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL invalid_period_missing pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_enable();
        cyc(1000);
        en = 1'b0;
        cyc(3);
        checks++;
        if (period !== CNT_W'(100) || sector !== 3'd0 || dir !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL en_hold got p=%0d s=%0d d=%0d stall=%0d exp 100 0 0 0", period, sector, dir, stall);
        end
        en = 1'b1;
        cyc(100);
        drive(3'b011, 0, 0, 0, 0);
        cyc(LAT + 1);
        checks++;
        if (sector !== 3'd1 || period !== CNT_W'(100)) begin
            errors++; $display("FAIL en_arm_edge got s=%0d p=%0d exp s=1 p=100", sector, period);
        end
        cyc(4200 - LAT - 1);
        drive(3'b010, 1, 100, 1'b1, 3'd2);
        cyc(LAT + 1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL en_rearm_missing pending=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        cyc(1500);
        rst = 1'b1;
        cyc(1);
        checks++;
        if (period !== '0 || sector !== 3'd7 || dir !== 1'b1 || stall !== 1'b0 ||
            period_valid !== 1'b0 || hall_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid got p=%0d s=%0d d=%0d stall=%0d v=%0d err=%0d exp 0 7 1 0 0 0",
                               period, sector, dir, stall, period_valid, hall_err);
        end
        rst = 1'b0;
        cyc(20);
    endtask

`ifdef HALL_FILTER_EN
    task automatic test_filter();
        int bad;
        int e0;
        bad = 0;
        e0  = err_pulses;
        checks++;
        if (sector !== 3'd2) begin errors++; $display("FAIL filt_start got=%0d exp=2", sector); end
        hall = 3'b011;
        cyc(3);
        hall = 3'b010;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            if (sector !== 3'd2) bad++;
        end
        checks++;
        if (bad != 0 || err_pulses != e0) begin
            errors++; $display("FAIL filt_glitch got bad=%0d err=%0d exp 0 0", bad, err_pulses - e0);
        end
        hall = 3'b011;
        cyc(LAT - 1);
        checks++;
        if (sector !== 3'd2) begin errors++; $display("FAIL filt_hold_early got=%0d exp=2", sector); end
        cyc(1);
        checks++;
        if (sector !== 3'd1) begin errors++; $display("FAIL filt_hold_accept got=%0d exp=1", sector); end
    endtask
`endif

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_forward();
        test_skip_reverse();
        test_stall();
        test_invalid();
        test_enable();
        test_reset_mid();
`ifdef HALL_FILTER_EN
        test_filter();
`endif
        cyc(5);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover pending=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
